clk_div_meter: RTL and testbench
================================

# clk_div_meter

Measures a divided clock produced inside the `clk_in` domain: high time, low time and full period in `clk_in` cycles. It compares each period against an expected divisor and flags mismatches. The block sits beside `clock_gen` as its checker; one instance is tapped onto any divider output, e.g. `clk_div_26` or `clk_div_3`, for on-board self-test and bench verification.

## Interface
Parameters:
- `CNT_W`, default 8: width of the high-time and low-time counters; each saturates at 2^CNT_W-1.

Ports:
- `clk_in` in 1: measurement clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `clk_meas` in 1: divided clock under test; treated as a level and sampled on `clk_in`.
- `exp_period` in CNT_W+1: expected period in `clk_in` cycles; must be held stable while measuring.
- `meas_valid` out 1: one-cycle pulse; the outputs below are updated in the same cycle.
- `period` out CNT_W+1: hi_cnt+lo_cnt of the last complete period; holds until the next update.
- `high_time` out CNT_W: hi_cnt of the last complete period.
- `mismatch` out 1: (`period` != `exp_period`) OR `ovf`; updated with `meas_valid`.
- `ovf` out 1: either counter saturated during the reported period.
- `stuck` out 1: level; the counter in the current phase is saturated.
- `err_cnt` out 8: saturating count of reported mismatches; holds at 255.

## Operation
- Sampler: register `m` captures `clk_meas` (or the synchronizer output, see Configuration). `m_d` delays `m` by one cycle. Both registers reset to 1, so a signal that is already high at reset exit is never taken as a rising edge.
- rise = m & ~m_d; fall = ~m & m_d.
- FSM states: IDLE, HIGH, LOW. Reset state is IDLE.
  - IDLE: on rise, set hi_cnt<=1, lo_cnt<=0, go to HIGH. Otherwise stay in IDLE.
  - HIGH: if m=1, hi_cnt++ (saturating). On fall, set lo_cnt<=1 and go to LOW.
  - LOW: if m=0, lo_cnt++ (saturating). On rise, report, then set hi_cnt<=1, lo_cnt<=0 and go to HIGH.
- Report: period<=hi_cnt+lo_cnt (zero-extended to CNT_W+1). high_time<=hi_cnt. ovf<=sticky saturation flag. mismatch computed from the new values. meas_valid<=1. err_cnt++ if mismatch and err_cnt<255.
- The sticky saturation flag is set when either counter reaches 2^CNT_W-1. It is cleared on every report.
- `stuck`:
  - asserts in the cycle hi_cnt (in HIGH) or lo_cnt (in LOW) reaches 2^CNT_W-1;
  - deasserts on the next phase change (fall or rise);
  - is never asserted in IDLE.
- No report is made on the first rise after reset. The first meas_valid follows the second rise.
- A fall while in IDLE is ignored.

## Timing
- Reset values:
  - meas_valid=0, period=0, high_time=0, mismatch=0, ovf=0, stuck=0, err_cnt=0;
  - hi_cnt=lo_cnt=0, state IDLE, m=m_d=1.
- Reset applies at the clock edge where rst=1. Asserting rst mid-measurement discards the partial period, and no meas_valid is produced in that cycle.
- Latency without the synchronizer: edge N is the first edge at which `m` samples 1 after a low phase. meas_valid is high during the cycle after edge N+1.
- Sustained rate: at most one meas_valid per measured period. With a period of 2, meas_valid is high every other cycle.
- Counts reflect sampled levels. For example, div_3 with pos/neg OR sampled on posedge appears as 2 high / 1 low: period 3, high_time 2.

## Configuration
- `CLK_METER_SYNC_EN` defined: a 2-flop synchronizer precedes `m` (both flops reset to 1). Use this for `clk_meas` derived from negedge logic or another domain. Latency grows by 2 cycles; counts are unchanged.
- Undefined: `m` samples `clk_meas` directly.

## Test plan
- Square wave, 1 high / 1 low, exp_period=2 -> after the 2nd rise, meas_valid every 2 cycles with period=2, high_time=1, mismatch=0, err_cnt=0.
- 13 high / 13 low, exp_period=26 -> period=26, high_time=13, mismatch=0. Then set exp_period=32 -> mismatch=1 on each report, err_cnt counts up and holds at 255.
- 2 high / 1 low, exp_period=3 -> period=3, high_time=2. With CLK_METER_SYNC_EN, the same values appear 2 cycles later.
- clk_meas held high for 300 cycles, CNT_W=8 -> stuck=1 once hi_cnt=255. Then 5 low cycles and a rise -> meas_valid with period=260, high_time=255, ovf=1, mismatch=1. stuck clears at the fall.
- rst pulsed for 1 cycle mid-LOW -> all outputs at reset values the next cycle; no meas_valid until the 2nd rise after reset.
- clk_meas already high at reset release -> the first valid report covers only a full period bounded by two genuine rises; no report is made from the initial high level.

Source files
------------

// File: rtl/clk_div_meter.sv
// clk_div_meter: measures high time, low time and period of a divided clock
// sampled in the clk_in domain, and flags periods that differ from exp_period.
// Optional macro CLK_METER_SYNC_EN inserts a 2-flop synchronizer ahead of the
// sampler for clk_meas sources that are not posedge clk_in registers.
module clk_div_meter #(
   parameter int CNT_W = 8
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             clk_meas,
   input  logic [CNT_W:0]   exp_period,
   output logic             meas_valid,
   output logic [CNT_W:0]   period,
   output logic [CNT_W-1:0] high_time,
   output logic             mismatch,
   output logic             ovf,
   output logic             stuck,
   output logic [7:0]       err_cnt
);

   localparam logic [1:0]       S_IDLE  = 2'd0;
   localparam logic [1:0]       S_HIGH  = 2'd1;
   localparam logic [1:0]       S_LOW   = 2'd2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             m_src;
   logic             m_q, m_dly_q;
   logic             rise, fall;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             sat_q, sat_d;
   logic             report;
   logic [CNT_W:0]   period_d;
   logic             mismatch_d;

   logic             meas_valid_q;
   logic [CNT_W:0]   period_q;
   logic [CNT_W-1:0] high_time_q;
   logic             mismatch_q, ovf_q;
   logic [7:0]       err_cnt_q;

`ifdef CLK_METER_SYNC_EN
   logic sync1_q, sync2_q;

   // Two-flop synchronizer; resets high so no false rise appears at reset exit.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= clk_meas;
         sync2_q <= sync1_q;
      end
   end

   assign m_src = sync2_q;
`else
   assign m_src = clk_meas;
`endif

   // Sample the measured level and keep one cycle of history for edge detect.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         m_q     <= 1'b1;
         m_dly_q <= 1'b1;
      end else begin
         m_q     <= m_src;
         m_dly_q <= m_q;
      end
   end

   assign rise = m_q & ~m_dly_q;
   assign fall = ~m_q & m_dly_q;

   // Phase FSM: count sampled high and low cycles, report on each rise from LOW.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      report  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rise) begin
               hi_d    = CNT_W'(1);
               lo_d    = '0;
               state_d = S_HIGH;
            end
         end
         S_HIGH: begin
            if (m_q && hi_q != CNT_MAX) hi_d = hi_q + CNT_W'(1);
            if (fall) begin
               lo_d    = CNT_W'(1);
               state_d = S_LOW;
            end
         end
         S_LOW: begin
            if (!m_q && lo_q != CNT_MAX) lo_d = lo_q + CNT_W'(1);
            if (rise) begin
               report  = 1'b1;
               hi_d    = CNT_W'(1);
               lo_d    = '0;
               state_d = S_HIGH;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Sticky saturation: cleared by a report, set whenever a counter hits max.
      sat_d = (report ? 1'b0 : sat_q) | (hi_d == CNT_MAX) | (lo_d == CNT_MAX);
   end

   assign period_d   = {1'b0, hi_q} + {1'b0, lo_q};
   assign mismatch_d = (period_d != exp_period) | sat_q;

   // FSM and counter state.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sat_q   <= sat_d;
      end
   end

   // Report registers: updated together with the meas_valid pulse, held otherwise.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         meas_valid_q <= 1'b0;
         period_q     <= '0;
         high_time_q  <= '0;
         mismatch_q   <= 1'b0;
         ovf_q        <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         meas_valid_q <= report;
         if (report) begin
            period_q    <= period_d;
            high_time_q <= hi_q;
            ovf_q       <= sat_q;
            mismatch_q  <= mismatch_d;
            if (mismatch_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   // stuck is a level derived from the live phase counter; never set in IDLE.
   assign stuck = ((state_q == S_HIGH) && (hi_q == CNT_MAX)) ||
                  ((state_q == S_LOW)  && (lo_q == CNT_MAX));

   assign meas_valid = meas_valid_q;
   assign period     = period_q;
   assign high_time  = high_time_q;
   assign mismatch   = mismatch_q;
   assign ovf        = ovf_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_clk_div_meter.sv
// Testbench for clk_div_meter: directed waveforms plus random phases, checked
// against a model that finds rises in the sampled level history and counts
// levels between consecutive rises.
module tb_clk_div_meter;

   localparam int CNT_W = 8;
   localparam int SAT   = (1 << CNT_W) - 1;
`ifdef CLK_METER_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 0;
`endif

   logic             clk_in;
   logic             rst;
   logic             clk_meas;
   logic [CNT_W:0]   exp_period;
   logic             meas_valid;
   logic [CNT_W:0]   period;
   logic [CNT_W-1:0] high_time;
   logic             mismatch;
   logic             ovf;
   logic             stuck;
   logic [7:0]       err_cnt;

   clk_div_meter #(.CNT_W(CNT_W)) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .clk_meas   (clk_meas),
      .exp_period (exp_period),
      .meas_valid (meas_valid),
      .period     (period),
      .high_time  (high_time),
      .mismatch   (mismatch),
      .ovf        (ovf),
      .stuck      (stuck),
      .err_cnt    (err_cnt)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   // Reference model state: driven levels and effective sampled levels since reset.
   bit raw[$];
   bit eff[$];
   int rises[$];
   int e_valid, e_period, e_high, e_mis, e_ovf, e_stuck, e_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      raw.delete(); eff.delete(); rises.delete();
      e_valid = 0; e_period = 0; e_high = 0; e_mis = 0; e_ovf = 0; e_stuck = 0; e_err = 0;
   endtask

   // Advance the model by one clk_in edge at which the sampler took level v.
   task automatic model_edge(input bit v);
      int n, r, ones, zeros, hi, lo, runlen;
      bit e;
      raw.push_back(v);
      n = raw.size() - 1;
      e = (n < S) ? 1'b1 : raw[n - S];
      eff.push_back(e);
      e_valid = 0;
      // A rise sampled at edge n-1 is acted on at edge n.
      if (n >= 2 && eff[n-1] == 1 && eff[n-2] == 0) begin
         if (rises.size() > 0) begin
            r = rises[$];
            ones = 0; zeros = 0;
            for (int i = r; i <= n - 2; i++) if (eff[i]) ones++; else zeros++;
            hi = (ones > SAT) ? SAT : ones;
            lo = (zeros > SAT) ? SAT : zeros;
            e_valid  = 1;
            e_period = hi + lo;
            e_high   = hi;
            e_ovf    = (ones >= SAT || zeros >= SAT) ? 1 : 0;
            e_mis    = (e_period != int'(exp_period) || e_ovf == 1) ? 1 : 0;
            if (e_mis == 1 && e_err < 255) e_err++;
         end
         rises.push_back(n - 1);
      end
      // stuck: a phase is active and its current run of equal levels is >= max.
      e_stuck = 0;
      if (rises.size() > 0 && n >= 1) begin
         runlen = 0;
         for (int i = n - 1; i >= 0 && eff[i] == eff[n-1]; i--) runlen++;
         if (runlen >= SAT) e_stuck = 1;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".meas_valid"}, 32'(meas_valid), 32'(e_valid));
      chk({tag, ".period"},     32'(period),     32'(e_period));
      chk({tag, ".high_time"},  32'(high_time),  32'(e_high));
      chk({tag, ".mismatch"},   32'(mismatch),   32'(e_mis));
      chk({tag, ".ovf"},        32'(ovf),        32'(e_ovf));
      chk({tag, ".stuck"},      32'(stuck),      32'(e_stuck));
      chk({tag, ".err_cnt"},    32'(err_cnt),    32'(e_err));
   endtask

   // One clk_in cycle with clk_meas = v; inputs change 1 time unit after the edge.
   task automatic step(input bit v, input string tag);
      clk_meas = v;
      @(posedge clk_in);
      #1;
      if (rst) model_reset();
      else model_edge(v);
      check_all(tag);
   endtask

   task automatic phase(input int h, input int l, input string tag);
      repeat (h) step(1'b1, tag);
      repeat (l) step(1'b0, tag);
   endtask

   task automatic pulse_reset(input bit v, input string tag);
      rst = 1'b1;
      step(v, tag);
      rst = 1'b0;
   endtask

   initial begin
      int h, l;
      rst = 1'b1;
      clk_meas = 1'b0;
      exp_period = 9'd2;
      @(posedge clk_in);
      model_reset();
      step(1'b0, "reset");
      rst = 1'b0;

      // 1 high / 1 low, matching expectation.
      step(1'b0, "sq2");
      repeat (20) phase(1, 1, "sq2");

      // 13/13 matching, then mismatching expectation.
      exp_period = 9'd26;
      repeat (3) phase(13, 13, "div26");
      exp_period = 9'd32;
      repeat (3) phase(13, 13, "div26_mis");

      // Fast mismatching reports to drive err_cnt into saturation.
      exp_period = 9'd3;
      repeat (262) phase(1, 1, "err_sat");

      // 2 high / 1 low.
      exp_period = 9'd3;
      repeat (6) phase(2, 1, "div3");

      // Long high phase saturates the high counter, then a short low phase.
      exp_period = 9'd260;
      phase(300, 5, "stuck");
      phase(3, 3, "stuck_after");

      // Reset mid-LOW discards the partial period.
      pulse_reset(1'b0, "rst_mid");
      step(1'b0, "rst_mid");
      exp_period = 9'd8;
      phase(4, 2, "rst_mid");
      pulse_reset(1'b0, "rst_mid_pulse");
      repeat (4) phase(4, 4, "after_rst");

      // clk_meas already high when reset releases.
      exp_period = 9'd7;
      pulse_reset(1'b1, "rst_high");
      repeat (3) phase(3, 4, "start_high");

      // Random phase lengths, half of them with a matching expectation.
      for (int k = 0; k < 60; k++) begin
         h = int'($urandom_range(1, 12));
         l = int'($urandom_range(1, 12));
         if ($urandom_range(0, 1) == 1) exp_period = 9'(h + l);
         else exp_period = 9'($urandom_range(2, 30));
         phase(h, l, "rand");
         if (k == 30) pulse_reset(1'($urandom_range(0, 1)), "rand_rst");
      end
      step(1'b1, "tail");
      step(1'b1, "tail");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
